bnn_fc_packer: RTL and testbench

BNN_FC_PACKER -- requirements
Module: bnn_fc_packer

---
 rtl/bnn_pkg.sv | 14 +
 rtl/bnn_binarize.sv | 24 ++
 rtl/bnn_fc_packer.sv | 126 ++++++++++++
 tb/tb_bnn_fc_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared BNN constants and the packer FSM state type, used by the packer and the FC layer.
package bnn_pkg;

    localparam int LANES    = 16;
    localparam int ACT_W    = 8;
    localparam int VEC_BITS = 400;
    localparam int BEATS    = VEC_BITS / LANES;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/bnn_binarize.sv
// Combinational per-lane sign binarizer: a lane bit is 1 when its signed activation is >= THRESH.
module bnn_binarize #(
    parameter int LANES  = 16,
    parameter int ACT_W  = 8,
    parameter int THRESH = 0
) (
    input  logic [LANES*ACT_W-1:0] act,
    output logic [LANES-1:0]       bits
);

    localparam logic signed [ACT_W-1:0] TH = ACT_W'(THRESH);

    logic signed [ACT_W-1:0] lane;

    always_comb begin
        bits = '0;
        lane = '0;
        for (int l = 0; l < LANES; l++) begin
            lane    = act[l*ACT_W +: ACT_W];
            bits[l] = (lane >= TH);
        end
    end

endmodule

// File: rtl/bnn_fc_packer.sv
// Packs binarized activation beats into one VEC_BITS-wide vector for the FC layer,
// with one output register plus one held vector of back-pressure buffering.
module bnn_fc_packer
    import bnn_pkg::*;
#(
    parameter int LANES    = bnn_pkg::LANES,
    parameter int ACT_W    = bnn_pkg::ACT_W,
    parameter int VEC_BITS = bnn_pkg::VEC_BITS,
    parameter int THRESH   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*ACT_W-1:0] s_data,
    input  logic                   s_last,
    output logic                   fc_in_valid,
    input  logic                   fc_ready,
    output logic [VEC_BITS-1:0]    input_vector,
    output logic                   err_len,
    output logic [15:0]            vec_count,
    output pack_state_t            pack_state
);

    // Handshakes: a beat moves on any rising edge where s_valid && s_ready, a vector
    // on any rising edge where fc_in_valid && fc_ready; valid never waits on ready.

    localparam int BEATS = VEC_BITS / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    logic [LANES-1:0]    lane_bits;
    logic [VEC_BITS-1:0] pack_reg;
    logic [VEC_BITS-1:0] hold_reg;
    logic [VEC_BITS-1:0] out_reg;
    logic [VEC_BITS-1:0] packed_next;
    logic [CW-1:0]       beat_cnt;
    logic                out_valid;
    logic                ready_r;
    logic                err_r;
    logic [15:0]         cnt_r;
    pack_state_t         state_r;

    logic beat_fire, drain, last_beat, complete, out_free;

    bnn_binarize #(
        .LANES (LANES),
        .ACT_W (ACT_W),
        .THRESH(THRESH)
    ) u_binarize (
        .act (s_data),
        .bits(lane_bits)
    );

    // New beat enters at the top and shifts down, so beat 0 ends at the low bits.
    if (BEATS == 1) begin : g_single
        assign packed_next = lane_bits;
    end else begin : g_multi
        assign packed_next = {lane_bits, pack_reg[VEC_BITS-1:LANES]};
    end

    assign beat_fire = s_valid && ready_r;
    assign drain     = out_valid && fc_ready;
    assign last_beat = (beat_cnt == LAST_IDX);
    assign complete  = beat_fire && last_beat;
    assign out_free  = !out_valid || drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            pack_reg  <= '0;
            hold_reg  <= '0;
            out_reg   <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            cnt_r     <= '0;
            state_r   <= FILL;
        end else begin
            err_r   <= 1'b0;
            ready_r <= (state_r == FILL);
            if (beat_fire) begin
                pack_reg <= packed_next;
                err_r    <= (s_last != last_beat);
                // Early s_last abandons the partial vector by restarting the count.
                if (last_beat || s_last) beat_cnt <= '0;
                else                     beat_cnt <= beat_cnt + 1'b1;
            end
            if (drain) begin
                out_valid <= 1'b0;
                cnt_r     <= cnt_r + 16'd1;
            end
            case (state_r)
                FILL: begin
                    if (complete) begin
                        if (out_free) begin
                            out_reg   <= packed_next;
                            out_valid <= 1'b1;
                        end else begin
                            hold_reg <= packed_next;
                            state_r  <= HOLD;
                            ready_r  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        out_reg   <= hold_reg;
                        out_valid <= 1'b1;
                        state_r   <= FILL;
                        ready_r   <= 1'b1;
                    end
                end
                default: state_r <= FILL;
            endcase
        end
    end

    assign s_ready      = ready_r;
    assign fc_in_valid  = out_valid;
    assign input_vector = out_reg;
    assign err_len      = err_r;
    assign vec_count    = cnt_r;
    assign pack_state   = state_r;

endmodule

// File: tb/tb_bnn_fc_packer.sv
// Directed bench for bnn_fc_packer: default 400-bit instance plus a one-beat instance for count wrap.
module tb_bnn_fc_packer;

    logic         clk;
    logic         reset;
    logic         s_valid, s_ready, s_last;
    logic [127:0] s_data;
    logic         fc_in_valid, fc_ready, err_len;
    logic [399:0] input_vector;
    logic [15:0]  vec_count;
    bnn_pkg::pack_state_t pack_state;

    logic         w_s_valid, w_s_ready, w_s_last;
    logic [127:0] w_s_data;
    logic         w_fc_in_valid, w_fc_ready, w_err_len;
    logic [15:0]  w_input_vector;
    logic [15:0]  w_vec_count;
    bnn_pkg::pack_state_t w_pack_state;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [7:0] mix_val [6] = '{8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h01};
    logic       mix_bit [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    bnn_fc_packer dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fc_in_valid(fc_in_valid), .fc_ready(fc_ready), .input_vector(input_vector),
        .err_len(err_len), .vec_count(vec_count), .pack_state(pack_state)
    );

    bnn_fc_packer #(.LANES(16), .ACT_W(8), .VEC_BITS(16), .THRESH(0)) dut_wrap (
        .clk(clk), .reset(reset),
        .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data), .s_last(w_s_last),
        .fc_in_valid(w_fc_in_valid), .fc_ready(w_fc_ready), .input_vector(w_input_vector),
        .err_len(w_err_len), .vec_count(w_vec_count), .pack_state(w_pack_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat_data(input int kind, input int k);
        logic [127:0] d;
        d = '0;
        case (kind)
            0: d = {16{8'h05}};
            1: d = {8{16'h00FF}};
            default: for (int l = 0; l < 16; l++) d[l*8 +: 8] = mix_val[(5*k + l) % 6];
        endcase
        return d;
    endfunction

    function automatic logic [399:0] mix_exp();
        logic [399:0] r;
        r = '0;
        for (int k = 0; k < 25; k++)
            for (int l = 0; l < 16; l++)
                r[k*16 + l] = mix_bit[(5*k + l) % 6];
        return r;
    endfunction

    // Returns #1 after the edge that transferred the beat.
    task automatic send_beat(input logic [127:0] d, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("s_ready_timeout", s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vec(input int kind, input int last_at);
        for (int k = 0; k < 25; k++) send_beat(beat_data(kind, k), k == last_at);
    endtask

    logic [399:0] ones_v, alt_v, mix_v;
    logic         seen;
    logic         v;
    int           xfers, cyc;

    initial begin
        ones_v = {400{1'b1}};
        alt_v  = {100{4'hA}};
        mix_v  = mix_exp();
        reset = 1'b1; s_valid = 0; s_last = 0; s_data = '0; fc_ready = 0;
        w_s_valid = 0; w_s_last = 0; w_s_data = '0; w_fc_ready = 0;

        tick(); tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_fc_in_valid", fc_in_valid, 0);
        chk("rst_input_vector", input_vector, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_vec_count", vec_count, 0);
        chk("rst_state", pack_state, bnn_pkg::FILL);
        reset = 1'b0;
        tick();
        chk("rel_s_ready", s_ready, 1);

        // All lanes +5 -> all ones, one cycle after the last beat, valid for one cycle
        fc_ready = 1'b1;
        send_vec(0, 24);
        chk("ones_valid", fc_in_valid, 1);
        chk("ones_vector", input_vector, ones_v);
        chk("ones_err", err_len, 0);
        tick();
        chk("ones_valid_drop", fc_in_valid, 0);
        chk("ones_count", vec_count, 1);

        send_vec(1, 24);
        chk("alt_vector", input_vector, alt_v);
        tick();
        chk("alt_count", vec_count, 2);

        send_vec(2, 24);
        chk("mix_valid", fc_in_valid, 1);
        chk("mix_vector", input_vector, mix_v);
        tick();
        chk("mix_count", vec_count, 3);

        // Back-pressure: two vectors queued, first held stable
        fc_ready = 1'b0;
        send_vec(0, 24);
        chk("bp_v1_valid", fc_in_valid, 1);
        send_vec(1, 24);
        chk("bp_s_ready_low", s_ready, 0);
        chk("bp_state_hold", pack_state, bnn_pkg::HOLD);
        chk("bp_v1_vector", input_vector, ones_v);
        tick(); tick(); tick();
        chk("bp_v1_stable", input_vector, ones_v);
        chk("bp_v1_valid_stable", fc_in_valid, 1);
        chk("bp_s_ready_still_low", s_ready, 0);
        fc_ready = 1'b1;
        tick();
        chk("bp_v2_vector", input_vector, alt_v);
        chk("bp_v2_valid", fc_in_valid, 1);
        chk("bp_s_ready_back", s_ready, 1);
        chk("bp_state_fill", pack_state, bnn_pkg::FILL);
        chk("bp_count1", vec_count, 4);
        tick();
        chk("bp_valid_drop", fc_in_valid, 0);
        chk("bp_count2", vec_count, 5);

        // s_last on beat 10 discards the partial vector
        for (int k = 0; k < 10; k++) send_beat(beat_data(0, k), 1'b0);
        send_beat(beat_data(0, 10), 1'b1);
        chk("early_err", err_len, 1);
        chk("early_no_valid", fc_in_valid, 0);
        tick();
        chk("early_err_pulse", err_len, 0);
        chk("early_no_valid2", fc_in_valid, 0);
        send_vec(2, 24);
        chk("early_next_valid", fc_in_valid, 1);
        chk("early_next_vector", input_vector, mix_v);
        chk("early_next_err", err_len, 0);
        tick();
        chk("early_count", vec_count, 6);

        // Missing s_last: error pulse but vector still issued
        send_vec(1, -1);
        chk("nolast_err", err_len, 1);
        chk("nolast_valid", fc_in_valid, 1);
        chk("nolast_vector", input_vector, alt_v);
        tick();
        chk("nolast_err_pulse", err_len, 0);
        chk("nolast_count", vec_count, 7);

        // Reset at beat 12 with a vector pending
        fc_ready = 1'b0;
        send_vec(1, 24);
        for (int k = 0; k < 12; k++) send_beat(beat_data(2, k), 1'b0);
        reset = 1'b1;
        tick();
        chk("mrst_valid", fc_in_valid, 0);
        chk("mrst_vector", input_vector, 0);
        chk("mrst_count", vec_count, 0);
        chk("mrst_s_ready", s_ready, 0);
        chk("mrst_err", err_len, 0);
        reset = 1'b0;
        fc_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            send_beat(beat_data(0, k), 1'b0);
            seen = seen | fc_in_valid;
        end
        chk("mrst_nothing_early", seen, 0);
        send_beat(beat_data(0, 24), 1'b1);
        chk("mrst_full_valid", fc_in_valid, 1);
        chk("mrst_full_vector", input_vector, ones_v);
        tick();
        chk("mrst_full_count", vec_count, 1);

        // vec_count wrap on the one-beat instance
        w_fc_ready = 1'b1;
        w_s_valid  = 1'b1;
        w_s_last   = 1'b1;
        w_s_data   = beat_data(0, 0);
        xfers = 0;
        cyc   = 0;
        while (xfers < 65536 && cyc < 70000) begin
            v = w_fc_in_valid;
            tick();
            cyc++;
            if (v) begin
                xfers++;
                if (xfers == 65535) chk("wrap_pre", w_vec_count, 16'hFFFF);
            end
        end
        w_s_valid = 1'b0;
        chk("wrap_xfers", xfers, 65536);
        chk("wrap_zero", w_vec_count, 0);
        chk("wrap_vector", w_input_vector, 16'hFFFF);
        chk("wrap_err", w_err_len, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
